packed_pixel_reader: RTL and testbench

- Reads 64-bit packed pixel words from the frame buffer RAM and unpacks each into four beats of two 8-bit pixels.
- Byte order is the same as the normalised-output packer. The first beat of each word is bits [63:56]/[55:48]. The last beat is bits [15:8]/[7:0].
- Sits between the frame buffer read port and downstream pixel consumers, such as the display/readback path and the next filter stage.
- Uses a valid/ready output handshake with backpressure.

---
 rtl/packed_pixel_reader.sv | 209 ++++++++++++++++++++
 tb/tb_packed_pixel_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_pixel_reader.sv
// Frame buffer word reader: fetches 64-bit packed words and streams them as four
// 2-pixel beats over valid/ready. Optional read-ahead buffer: PACKED_READER_PREFETCH_EN.
module packed_pixel_reader #(
    parameter int unsigned START_ADDRESS = 0,
    parameter int unsigned WORD_COUNT    = 65536,
    parameter int unsigned ADDR_WIDTH    = 20,
    parameter int unsigned READ_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [63:0]           rd_data,
    output logic [7:0]            pixel_byte1,
    output logic [7:0]            pixel_byte2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] START     = ADDR_WIDTH'(START_ADDRESS);
    localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(READ_LATENCY);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, FINISH} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       beat;
    logic [LAT_W-1:0] lat_cnt;
    logic             in_flight;
    logic [63:0]      hold;
    logic [63:0]      load_data;
    logic             handshake;
    logic             last_beat;
    logic             last_word;
    logic             arrive;
    logic             word_end;
    logic             load;
`ifdef PACKED_READER_PREFETCH_EN
    logic [63:0]      spare;
    logic             spare_valid;
    logic             pf_issue;
    logic             load_spare;
    logic             next_is_last;
`endif

    function automatic logic [15:0] beat_bytes(input logic [63:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[63:48];
            2'd1:    return word[47:32];
            2'd2:    return word[31:16];
            default: return word[15:0];
        endcase
    endfunction

    assign handshake = out_valid & out_ready;
    assign last_beat = (beat == 2'd3);
    assign last_word = (word_cnt == LAST_WORD);
    // Only one read is ever outstanding, so a single down-counter tracks its arrival.
    assign arrive    = in_flight && (lat_cnt == LAT_W'(1));
    assign word_end  = handshake && last_beat;
    assign busy      = (state == REQ) || (state == WAIT) || (state == UNPACK);
    assign done      = (state == FINISH);

`ifdef PACKED_READER_PREFETCH_EN
    assign rd_en        = (state == REQ) || pf_issue;
    assign load_data    = load_spare ? spare : rd_data;
    // At a swap the counter still names the outgoing word.
    assign next_is_last = (state == UNPACK) ? ((word_cnt + CNT_W'(1)) == LAST_WORD) : last_word;
`else
    assign rd_en        = (state == REQ);
    assign load_data    = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
`ifdef PACKED_READER_PREFETCH_EN
        load_spare = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (arrive) begin
                    load       = 1'b1;
                    next_state = UNPACK;
                end
            end
            UNPACK: begin
                if (word_end) begin
                    if (last_word) begin
                        next_state = FINISH;
                    end else begin
`ifdef PACKED_READER_PREFETCH_EN
                        if (spare_valid) begin
                            load       = 1'b1;
                            load_spare = 1'b1;
                        end else if (arrive) begin
                            load = 1'b1;
                        end else begin
                            next_state = WAIT;
                        end
`else
                        next_state = REQ;
`endif
                    end
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr     <= START;
            word_cnt    <= '0;
            beat        <= '0;
            lat_cnt     <= '0;
            in_flight   <= 1'b0;
            hold        <= '0;
            pixel_byte1 <= '0;
            pixel_byte2 <= '0;
            out_valid   <= 1'b0;
`ifdef PACKED_READER_PREFETCH_EN
            spare       <= '0;
            spare_valid <= 1'b0;
            pf_issue    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                rd_addr  <= START;
                word_cnt <= '0;
            end

            if (rd_en) begin
                in_flight <= 1'b1;
                lat_cnt   <= LAT_LOAD;
            end else if (in_flight) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
                if (arrive) begin
                    in_flight <= 1'b0;
                end
            end

            if (load) begin
                hold                       <= load_data;
                {pixel_byte1, pixel_byte2} <= beat_bytes(load_data, 2'd0);
                out_valid                  <= 1'b1;
                beat                       <= 2'd0;
            end else if (handshake) begin
                if (last_beat) begin
                    out_valid <= 1'b0;
                end else begin
                    beat                       <= beat + 2'd1;
                    {pixel_byte1, pixel_byte2} <= beat_bytes(hold, beat + 2'd1);
                end
            end

`ifdef PACKED_READER_PREFETCH_EN
            if (word_end && !last_word) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            // rd_addr runs one word ahead: it is bumped as each word starts unpacking.
            pf_issue <= load && !next_is_last;
            if (load && !next_is_last) begin
                rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end
            if (load_spare) begin
                spare_valid <= 1'b0;
            end else if (arrive && state == UNPACK && !load) begin
                spare       <= rd_data;
                spare_valid <= 1'b1;
            end
`else
            if (word_end && !last_word) begin
                rd_addr  <= rd_addr + ADDR_WIDTH'(1);
                word_cnt <= word_cnt + CNT_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_packed_pixel_reader.sv
// Bench for packed_pixel_reader: cycle table for single-word, backpressure and ignored
// starts, then multi-word, address-wrap, mid-run reset and random-ready runs.
`timescale 1ns/1ps
module tb_packed_pixel_reader;

    localparam int LAT = 2;
`ifdef PACKED_READER_PREFETCH_EN
    localparam int WORD_STEP = 1;
`else
    localparam int WORD_STEP = LAT + 2;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // single-word instance
    logic        start_s = 1'b0, ready_s = 1'b1;
    logic        rd_en_s, valid_s, busy_s, done_s;
    logic [19:0] rd_addr_s;
    logic [63:0] rd_data_s, pipe_s;
    logic [7:0]  b1_s, b2_s;
    // multi-word instance
    logic        start_m = 1'b0, ready_m = 1'b1;
    logic        rd_en_m, valid_m, busy_m, done_m;
    logic [19:0] rd_addr_m;
    logic [63:0] rd_data_m, pipe_m;
    logic [7:0]  b1_m, b2_m;
    // wrapping instance
    logic        start_w = 1'b0, ready_w = 1'b1;
    logic        rd_en_w, valid_w, busy_w, done_w;
    logic [3:0]  rd_addr_w;
    logic [63:0] rd_data_w, pipe_w;
    logic [7:0]  b1_w, b2_w;

    packed_pixel_reader #(.START_ADDRESS(32'h10), .WORD_COUNT(1), .ADDR_WIDTH(20), .READ_LATENCY(LAT)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
        .rd_data(rd_data_s), .pixel_byte1(b1_s), .pixel_byte2(b2_s), .out_valid(valid_s),
        .out_ready(ready_s), .busy(busy_s), .done(done_s));

    packed_pixel_reader #(.START_ADDRESS(0), .WORD_COUNT(3), .ADDR_WIDTH(20), .READ_LATENCY(LAT)) dut_m (
        .clk(clk), .reset(reset), .start(start_m), .rd_en(rd_en_m), .rd_addr(rd_addr_m),
        .rd_data(rd_data_m), .pixel_byte1(b1_m), .pixel_byte2(b2_m), .out_valid(valid_m),
        .out_ready(ready_m), .busy(busy_m), .done(done_m));

    packed_pixel_reader #(.START_ADDRESS(32'hF), .WORD_COUNT(2), .ADDR_WIDTH(4), .READ_LATENCY(LAT)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .rd_en(rd_en_w), .rd_addr(rd_addr_w),
        .rd_data(rd_data_w), .pixel_byte1(b1_w), .pixel_byte2(b2_w), .out_valid(valid_w),
        .out_ready(ready_w), .busy(busy_w), .done(done_w));

    function automatic logic [63:0] ram_word(input logic [19:0] a);
        if (a == 20'h10) return 64'h0102030405060708;
        return {a[7:0] ^ 8'h5A, 8'h11, a[7:0], 8'h22, ~a[7:0], 8'h33, a[7:0] + 8'h01, 8'h44};
    endfunction

    function automatic logic [15:0] exp_beat(input logic [19:0] a, input int k);
        logic [63:0] w;
        w = ram_word(a);
        return w[63 - 16 * k -: 16];
    endfunction

    // Two-stage RAM pipelines; off-cycle data is poisoned so a mistimed capture shows.
    always @(posedge clk) begin
        pipe_s    <= rd_en_s ? ram_word(rd_addr_s) : 64'hDEADBEEFDEADBEEF;
        rd_data_s <= pipe_s;
        pipe_m    <= rd_en_m ? ram_word(rd_addr_m) : 64'hDEADBEEFDEADBEEF;
        rd_data_m <= pipe_m;
        pipe_w    <= rd_en_w ? ram_word({16'h0, rd_addr_w}) : 64'hDEADBEEFDEADBEEF;
        rd_data_w <= pipe_w;
    end

    logic [15:0] beats_m[$];
    int          beat_cyc_m[$];
    logic [19:0] addrs_m[$];
    int          dones_m = 0;
    logic [15:0] beats_w[$];
    logic [3:0]  addrs_w[$];
    int          dones_w = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (valid_m && ready_m) begin
                beats_m.push_back({b1_m, b2_m});
                beat_cyc_m.push_back(cyc);
            end
            if (rd_en_m) addrs_m.push_back(rd_addr_m);
            if (done_m) dones_m++;
            if (valid_w && ready_w) beats_w.push_back({b1_w, b2_w});
            if (rd_en_w) addrs_w.push_back(rd_addr_w);
            if (done_w) dones_w++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_m(input string tag, input bit rnd);
        int bb, ab, db;
        bb = beats_m.size();
        ab = addrs_m.size();
        db = dones_m;
        ready_m = 1'b1;
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        for (int k = 0; k < 400 && dones_m == db; k++) begin
            if (rnd) begin
                @(posedge clk);
                #1 ready_m = 1'($urandom_range(0, 1));
            end else begin
                @(negedge clk);
            end
        end
        ready_m = 1'b1;
        @(negedge clk);
        #1;
        check({tag, "_done_count"}, dones_m - db, 1);
        check({tag, "_busy_after"}, busy_m, 1'b0);
        check({tag, "_rd_count"}, addrs_m.size() - ab, 3);
        for (int j = 0; j < 3; j++)
            if (ab + j < addrs_m.size()) check($sformatf("%s_addr%0d", tag, j), addrs_m[ab + j], j);
        check({tag, "_beat_count"}, beats_m.size() - bb, 12);
        for (int j = 0; j < 12; j++)
            if (bb + j < beats_m.size())
                check($sformatf("%s_beat%0d", tag, j), beats_m[bb + j], exp_beat(20'(j / 4), j % 4));
        if (!rnd && beats_m.size() - bb >= 12) begin
            check({tag, "_in_word_step"}, beat_cyc_m[bb + 1] - beat_cyc_m[bb], 1);
            check({tag, "_word_step01"}, beat_cyc_m[bb + 4] - beat_cyc_m[bb + 3], WORD_STEP);
            check({tag, "_word_step12"}, beat_cyc_m[bb + 8] - beat_cyc_m[bb + 7], WORD_STEP);
        end
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       exp_rd_en;
        logic       exp_valid;
        logic [7:0] exp_b1;
        logic [7:0] exp_b2;
        logic       exp_busy;
        logic       exp_done;
    } row_t;

    row_t tbl[25];

    initial begin
        int seen, db, ab, bw, aw, dw;
        // {start, ready} driven after the check; expectations are the outputs seen at that row
        tbl[0]  = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 8'h00, 8'h00, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[4]  = '{0, 1, 0, 1, 8'h01, 8'h02, 1, 0};
        tbl[5]  = '{0, 1, 0, 1, 8'h03, 8'h04, 1, 0};
        tbl[6]  = '{1, 1, 0, 1, 8'h05, 8'h06, 1, 0};
        tbl[7]  = '{0, 1, 0, 1, 8'h07, 8'h08, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 8'h00, 8'h00, 1, 0};
        tbl[12] = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[13] = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[14] = '{0, 1, 0, 1, 8'h01, 8'h02, 1, 0};
        tbl[15] = '{0, 0, 0, 1, 8'h03, 8'h04, 1, 0};
        tbl[16] = '{0, 0, 0, 1, 8'h03, 8'h04, 1, 0};
        tbl[17] = '{0, 0, 0, 1, 8'h03, 8'h04, 1, 0};
        tbl[18] = '{0, 0, 0, 1, 8'h03, 8'h04, 1, 0};
        tbl[19] = '{0, 0, 0, 1, 8'h03, 8'h04, 1, 0};
        tbl[20] = '{0, 1, 0, 1, 8'h03, 8'h04, 1, 0};
        tbl[21] = '{0, 1, 0, 1, 8'h05, 8'h06, 1, 0};
        tbl[22] = '{0, 1, 0, 1, 8'h07, 8'h08, 1, 0};
        tbl[23] = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 1};
        tbl[24] = '{0, 1, 0, 0, 8'h00, 8'h00, 0, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_rd_en", rd_en_s, 1'b0);
        check("rst_valid", valid_s, 1'b0);
        check("rst_byte1", b1_s, 8'h00);
        check("rst_byte2", b2_s, 8'h00);
        check("rst_busy", busy_s, 1'b0);
        check("rst_done", done_s, 1'b0);
        check("rst_addr_s", rd_addr_s, 20'h10);
        check("rst_addr_m", rd_addr_m, 20'h0);
        check("rst_addr_w", rd_addr_w, 4'hF);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check($sformatf("row%0d_rd_en", i), rd_en_s, tbl[i].exp_rd_en);
            check($sformatf("row%0d_valid", i), valid_s, tbl[i].exp_valid);
            check($sformatf("row%0d_busy", i), busy_s, tbl[i].exp_busy);
            check($sformatf("row%0d_done", i), done_s, tbl[i].exp_done);
            check($sformatf("row%0d_addr", i), rd_addr_s, 20'h10);
            if (tbl[i].exp_valid) begin
                check($sformatf("row%0d_byte1", i), b1_s, tbl[i].exp_b1);
                check($sformatf("row%0d_byte2", i), b2_s, tbl[i].exp_b2);
            end
            start_s = tbl[i].start;
            ready_s = tbl[i].ready;
        end
        start_s = 1'b0;

        run_m("multi", 1'b0);

        // wrap: 0xF then 0x0 on a 4-bit address
        bw = beats_w.size();
        aw = addrs_w.size();
        dw = dones_w;
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        for (int k = 0; k < 200 && dones_w == dw; k++) @(negedge clk);
        @(negedge clk);
        #1;
        check("wrap_done_count", dones_w - dw, 1);
        check("wrap_rd_count", addrs_w.size() - aw, 2);
        if (addrs_w.size() - aw >= 2) begin
            check("wrap_addr0", addrs_w[aw], 4'hF);
            check("wrap_addr1", addrs_w[aw + 1], 4'h0);
        end
        check("wrap_beat_count", beats_w.size() - bw, 8);
        for (int j = 0; j < 8; j++)
            if (bw + j < beats_w.size())
                check($sformatf("wrap_beat%0d", j), beats_w[bw + j], exp_beat((j < 4) ? 20'hF : 20'h0, j % 4));

        // reset during the wait for word 2
        db = dones_m;
        seen = 0;
        @(negedge clk) start_m = 1'b1;
        @(negedge clk) start_m = 1'b0;
        for (int k = 0; k < 60 && seen < 2; k++) begin
            @(negedge clk);
            if (rd_en_m) seen++;
        end
        check("rst_mid_second_req", seen, 2);
        @(negedge clk);
        check("rst_mid_in_wait", busy_m && !valid_m && !rd_en_m, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_rd_en", rd_en_m, 1'b0);
        check("rst_mid_valid", valid_m, 1'b0);
        check("rst_mid_busy", busy_m, 1'b0);
        check("rst_mid_done", done_m, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst_mid_no_done", dones_m - db, 0);
        check("rst_mid_idle", busy_m, 1'b0);

        ab = addrs_m.size();
        run_m("restart", 1'b1);
        if (addrs_m.size() > ab) check("restart_first_addr", addrs_m[ab], 20'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
